act_lut_reader: RTL

- Piecewise-linear activation evaluator. Consumes one NU_COUNT-lane Q4.12 vector from the neuron-unit outputs.
- Reads the host-written 64-entry activation coefficient LUT. Each entry is a 32-bit word: a in [31:16], b in [15:0]. The host writes the LUT over the MM bus; this block is the read side of that LUT.
- Computes y = a·x + b per lane and emits the vector toward output memory.
- Lanes are serialized through one LUT read port and one multiplier.

---
 rtl/act_lut_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/act_lut_reader.sv
// Piecewise-linear activation evaluator: y = a*x + b per lane, with {a,b} read from a
// host-written 64-entry coefficient LUT. Lanes share one LUT read port and one multiplier,
// so a vector takes NU_COUNT read slots plus one drain slot before it is presented.
module act_lut_reader #(
  parameter int unsigned NU_COUNT      = 4,
  parameter int unsigned Q_SIZE        = 16,
  parameter int unsigned Q_FRAC        = 12,
  parameter int unsigned ACT_LUT_DEPTH = 6,
  parameter int unsigned ACT_LUT_SIZE  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lut_wr_en,
  input  logic [ACT_LUT_DEPTH-1:0]     lut_wr_addr,
  input  logic [ACT_LUT_SIZE-1:0]      lut_wr_data,
  input  logic [NU_COUNT-1:0]          act_mask,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NU_COUNT*Q_SIZE-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NU_COUNT*Q_SIZE-1:0]   out_data,
  output logic                         busy
);

  localparam int unsigned LaneW      = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;
  localparam int unsigned LutEntries = 1 << ACT_LUT_DEPTH;
  localparam int unsigned ProdW      = 2 * Q_SIZE;
  localparam int unsigned VecW       = NU_COUNT * Q_SIZE;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NU_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StOut} state_e;

  state_e              state_q, state_d;
  logic [LaneW-1:0]    lane_q, lane_d;
  logic [VecW-1:0]     x_q, x_d;
  logic [NU_COUNT-1:0] mask_q, mask_d;
  logic [VecW-1:0]     res_q, res_d;
  logic [VecW-1:0]     out_data_q, out_data_d;

  logic [ACT_LUT_SIZE-1:0]  lut_mem [LutEntries];
  logic [ACT_LUT_SIZE-1:0]  rd_data_q;
  logic [ACT_LUT_DEPTH-1:0] rd_addr;

  logic [LaneW-1:0]         eval_lane;
  logic [Q_SIZE-1:0]        eval_x;
  logic [Q_SIZE-1:0]        coef_a, coef_b;
  logic signed [ProdW-1:0]  a_ext, x_ext, prod, prod_sh;
  logic [ProdW-1:0]         b_ext, sum;
  logic [Q_SIZE-1:0]        y_sat, y;

  // LUT index of the lane being addressed: flipping the sign bit makes the map monotonic in x
  always_comb begin
    rd_addr = {~x_q[lane_q*Q_SIZE + Q_SIZE - 1],
               x_q[lane_q*Q_SIZE + Q_SIZE - 2 -: ACT_LUT_DEPTH - 1]};
  end

  // Coefficient RAM: write any time, registered read; same-address collision returns old data
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      lut_mem[lut_wr_addr] <= lut_wr_data;
    end
    rd_data_q <= lut_mem[rd_addr];
  end

  // Evaluate the lane whose coefficients arrived this cycle (one behind the addressed lane)
  always_comb begin
    eval_lane = (state_q == StDrain) ? LastLane : lane_q - LaneW'(1);
    eval_x    = x_q[eval_lane*Q_SIZE +: Q_SIZE];
    coef_a    = rd_data_q[ACT_LUT_SIZE-1 -: Q_SIZE];
    coef_b    = rd_data_q[Q_SIZE-1:0];
    a_ext     = {{Q_SIZE{coef_a[Q_SIZE-1]}}, coef_a};
    x_ext     = {{Q_SIZE{eval_x[Q_SIZE-1]}}, eval_x};
    prod      = a_ext * x_ext;
    // Arithmetic shift floors toward -inf; no rounding term is added
    prod_sh   = prod >>> Q_FRAC;
    b_ext     = {{(ProdW - Q_SIZE){coef_b[Q_SIZE-1]}}, coef_b};
    sum       = prod_sh + b_ext;
    // In range only when all bits above the result sign bit agree with it
    if (sum[ProdW-1:Q_SIZE-1] == '0 || sum[ProdW-1:Q_SIZE-1] == '1) begin
      y_sat = sum[Q_SIZE-1:0];
    end else if (sum[ProdW-1]) begin
      y_sat = {1'b1, {(Q_SIZE - 1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(Q_SIZE - 1){1'b1}}};
    end
    y = mask_q[eval_lane] ? eval_x : y_sat;
  end

  // Next-state logic: accept, serialize lanes through the LUT, drain, hold until taken
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    x_d        = x_q;
    mask_d     = mask_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_data;
          mask_d  = act_mask;
          lane_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (lane_q != '0) begin
          res_d[eval_lane*Q_SIZE +: Q_SIZE] = y;
        end
        if (lane_q == LastLane) begin
          lane_d  = '0;
          state_d = StDrain;
        end else begin
          lane_d = lane_q + LaneW'(1);
        end
      end
      StDrain: begin
        res_d[eval_lane*Q_SIZE +: Q_SIZE] = y;
        // Output register only changes here so it stays stable between vectors
        out_data_d = res_d;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      x_q        <= '0;
      mask_q     <= '0;
      res_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      x_q        <= x_d;
      mask_q     <= mask_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;

endmodule
